data_mem_resp: RTL and testbench
================================

# data_mem_resp

Data-memory responder for the single-cycle RISC-V core. It is the memory-side end of the load/store control signals produced by the instruction decoder (Lw_Sw_OP, Store_Word_En, Read_Ctrl). It owns a word-organised data RAM and performs byte-lane steering, sign/zero extension and misaligned-access splitting. It stalls the core through Mem_Stall whenever an access needs more than the current cycle.

## Interface
- DEPTH, 1024: number of 32-bit words in the RAM; power of two.
- AW, 10: word-index width, equal to log2(DEPTH).
- Clk  input  1  core clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Addr  input  32  byte address, the ALU result.
- Wr_Data  input  32  store data (rs2); the low byte or halfword is used for SB/SH.
- Lw_Sw_OP  input  3  access size/type, funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (load only).
- Store_Word_En  input  1  store request.
- Read_Ctrl  input  1  load request.
- Rd_Data  output  32  extended load result; valid when Rd_Valid=1.
- Rd_Valid  output  1  load result valid this cycle.
- Mem_Stall  output  1  core must hold PC and instruction this cycle.

## Operation
- Request rules:
  - Read_Ctrl=1 is a load. Store_Word_En=1 is a store.
  - Both high is illegal. Treat it as a load and perform no write.
  - Requests are sampled only in IDLE. The core holds every input stable while Mem_Stall=1.
  - Lw_Sw_OP values 011, 110 and 111 are treated as word accesses.
- Address mapping:
  - Word index w = Addr[AW+1:2]. Upper address bits are ignored, so the space aliases modulo 4*DEPTH.
  - Byte offset o = Addr[1:0].
- Alignment:
  - An access is misaligned when (half and o=3) or (word and o≠0).
  - A misaligned access touches words w and (w+1) mod DEPTH; index DEPTH-1 wraps to 0.
- Stores:
  - The write uses byte enables. Data is shifted left by 8*o, and bytes beyond lane 3 spill into word w+1, lanes 0 upward.
  - Byte lanes not enabled are preserved.
- Loads:
  - Fetch the required word(s) and concatenate {word(w+1), word(w)}.
  - Shift right by 8*o and take 8/16/32 bits.
  - Sign-extend for 000/001 and zero-extend for 100/101.
- RAM: synchronous read, one-cycle latency; synchronous byte-enabled write.
- FSM states and transitions:
  - IDLE:
    - Aligned store: write word w at the edge and stay in IDLE. Mem_Stall=0.
    - Misaligned store: write the low part to w and go to ST1. Mem_Stall=1.
    - Load: issue a read of w. Go to RD1 if misaligned, otherwise DONE. Mem_Stall=1.
  - ST1: write the high part to w+1, then go to IDLE. Mem_Stall=0.
  - RD1: capture word w and issue a read of w+1, then go to DONE. Mem_Stall=1.
  - DONE: form Rd_Data, assert Rd_Valid=1 and Mem_Stall=0, then go to IDLE.
- Rst:
  - Forces IDLE from any state. An in-flight split access is abandoned.
  - The first half of a split store may already be written. The second half is never written.
  - RAM contents are not cleared.

## Timing
- Reset values: Rd_Data=0, Rd_Valid=0, Mem_Stall=0, state=IDLE.
- Mem_Stall is combinational from state and request inputs in the same cycle.
- Rd_Data and Rd_Valid are registered. They are asserted only in DONE and return to 0 on the next cycle.
- Latency, with request first presented in cycle N:
  - Aligned store: written at the end of N; 0 stall cycles.
  - Misaligned store: both words written by the end of N+1; 1 stall cycle.
  - Aligned load: data valid in N+1; 1 stall cycle.
  - Misaligned load: data valid in N+2; 2 stall cycles.
- The core advances at the end of the cycle with Mem_Stall=0.
- A new request is accepted in the cycle after DONE or ST1.
- Back-to-back aligned stores are accepted in consecutive cycles.
- A load in IDLE immediately following a store to the same word returns the new data, because the write completes before the read is issued.

## Test plan
- Word store then load:
  - Stimulus: SW 0xDEADBEEF to Addr 0x10, then LW 0x10.
  - Response: Mem_Stall high one cycle; Rd_Data=0xDEADBEEF with Rd_Valid=1 in the following cycle.
- Byte lanes and extension:
  - Stimulus: SB 0x80 to Addr 0x13, then LB 0x13 and LBU 0x13.
  - Response: LB returns 0xFFFFFF80, LBU returns 0x00000080, and the other bytes of word 4 are unchanged.
- Misaligned half:
  - Stimulus: SH 0xA55A to Addr 0x07, then LHU 0x07.
  - Response: byte 0x5A in word 1 lane 3 and 0xA5 in word 2 lane 0; Rd_Data=0x0000A55A after 2 stall cycles.
- Wrap-around:
  - Stimulus: with DEPTH=1024, SW 0x11223344 to Addr 0xFFE, then LW 0xFFE.
  - Response: word 1023 upper half = 0x3344 and word 0 lower half = 0x1122; load returns 0x11223344.
- Reset mid-operation:
  - Stimulus: assert Rst in the RD1 state of a misaligned LW.
  - Response: next cycle state=IDLE, Mem_Stall=0, Rd_Valid=0, and no Rd_Valid pulse follows.
- Illegal and no-op:
  - Stimulus: Read_Ctrl=Store_Word_En=1.
  - Response: treated as a load and RAM unchanged.
  - Stimulus: both low.
  - Response: Mem_Stall=0, no RAM write, Rd_Valid=0.

Source files
------------

// File: rtl/data_mem_resp_if.sv
// Load/store bus between the core's decode/ALU stage and the data-memory responder.
// Signal names follow the core's existing load/store port names.
interface data_mem_resp_if;
    logic [31:0] Addr;
    logic [31:0] Wr_Data;
    logic [2:0]  Lw_Sw_OP;
    logic        Store_Word_En;
    logic        Read_Ctrl;
    logic [31:0] Rd_Data;
    logic        Rd_Valid;
    logic        Mem_Stall;

    modport master (
        output Addr, Wr_Data, Lw_Sw_OP, Store_Word_En, Read_Ctrl,
        input  Rd_Data, Rd_Valid, Mem_Stall
    );

    modport slave (
        input  Addr, Wr_Data, Lw_Sw_OP, Store_Word_En, Read_Ctrl,
        output Rd_Data, Rd_Valid, Mem_Stall
    );
endinterface

// File: rtl/data_mem_resp.sv
// Word-organised data RAM with byte steering, load extension and misaligned splitting.
// Loads return in 1 (aligned) or 2 (split) stall cycles; split stores stall 1 cycle; Mem_Stall holds the core.
module data_mem_resp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic            Clk,
    input  logic            Rst,
    data_mem_resp_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ST1, RD1, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;
    logic [31:0]   lo_q;
    logic          rd_valid_q;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w1_idx;
    logic [1:0]    ofs;
    logic          is_byte, is_half, is_word, is_sgn;
    logic          mis;
    logic          is_load, is_store;

    logic [31:0]   st_base;
    logic [3:0]    be_base;
    logic [63:0]   st_wide;
    logic [7:0]    be_wide;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_dat;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic          stall;

    logic [63:0]   ld_cat;
    logic [63:0]   ld_sh;
    logic [31:0]   ld_ext;
    logic          unused_addr;

    assign w_idx    = bus.Addr[AW+1:2];
    assign w1_idx   = w_idx + 1'b1;
    assign ofs      = bus.Addr[1:0];
    assign unused_addr = ^bus.Addr[31:AW+2];

    assign is_byte  = (bus.Lw_Sw_OP[1:0] == 2'b00);
    assign is_half  = (bus.Lw_Sw_OP[1:0] == 2'b01);
    assign is_word  = bus.Lw_Sw_OP[1];
    assign is_sgn   = ~bus.Lw_Sw_OP[2];
    assign mis      = (is_half && ofs == 2'd3) || (is_word && ofs != 2'd0);

    // Simultaneous load and store requests resolve to a load.
    assign is_load  = bus.Read_Ctrl;
    assign is_store = bus.Store_Word_En & ~bus.Read_Ctrl;

    always_comb begin
        st_base = bus.Wr_Data;
        be_base = 4'b1111;
        if (is_byte) begin
            st_base = {24'b0, bus.Wr_Data[7:0]};
            be_base = 4'b0001;
        end else if (is_half) begin
            st_base = {16'b0, bus.Wr_Data[15:0]};
            be_base = 4'b0011;
        end
    end

    assign st_wide = {32'b0, st_base} << {ofs, 3'b000};
    assign be_wide = {4'b0, be_base} << ofs;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_idx    = w_idx;
        wr_be     = be_wide[3:0];
        wr_dat    = st_wide[31:0];
        rd_en     = 1'b0;
        rd_idx    = w_idx;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (is_load) begin
                    rd_en     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = mis ? RD1 : DONE;
                end else if (is_store) begin
                    wr_en = 1'b1;
                    if (mis) begin
                        stall     = 1'b1;
                        state_nxt = ST1;
                    end
                end
            end
            ST1: begin
                wr_en     = 1'b1;
                wr_idx    = w1_idx;
                wr_be     = be_wide[7:4];
                wr_dat    = st_wide[63:32];
                state_nxt = IDLE;
            end
            RD1: begin
                rd_en     = 1'b1;
                rd_idx    = w1_idx;
                stall     = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid_q <= (state_nxt == DONE);
        end
    end

    // Reset blocks any pending write, so an abandoned split store never writes its high half.
    always_ff @(posedge Clk) begin
        if (wr_en && !Rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
        if (rd_en) rd_q <= mem[rd_idx];
        if (state == RD1) lo_q <= rd_q;
    end

    assign ld_cat = mis ? {rd_q, lo_q} : {32'b0, rd_q};
    assign ld_sh  = ld_cat >> {ofs, 3'b000};

    always_comb begin
        ld_ext = ld_sh[31:0];
        if (is_byte)      ld_ext = {{24{is_sgn & ld_sh[7]}},  ld_sh[7:0]};
        else if (is_half) ld_ext = {{16{is_sgn & ld_sh[15]}}, ld_sh[15:0]};
    end

    assign bus.Rd_Data   = rd_valid_q ? ld_ext : 32'b0;
    assign bus.Rd_Valid  = rd_valid_q;
    assign bus.Mem_Stall = stall;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: stores and loads with hand-computed results,
// checking stall cycle counts, extension, split accesses, wrap, illegal/no-op and reset.
module tb_data_mem_resp;

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_fails;

    data_mem_resp_if bus_if ();

    data_mem_resp #(.DEPTH(1024), .AW(10)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus_if.Addr          = 32'h0;
        bus_if.Wr_Data       = 32'h0;
        bus_if.Lw_Sw_OP      = 3'b010;
        bus_if.Store_Word_En = 1'b0;
        bus_if.Read_Ctrl     = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] data, input int exp_stalls);
        int stalls = 0;
        bus_if.Addr          = addr;
        bus_if.Wr_Data       = data;
        bus_if.Lw_Sw_OP      = op;
        bus_if.Store_Word_En = 1'b1;
        bus_if.Read_Ctrl     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (!bus_if.Mem_Stall) break;
            stalls++;
            @(posedge Clk); #1;
        end
        check({tag, "_stalls"}, stalls, exp_stalls);
        @(posedge Clk); #1;
        idle_bus();
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                           input logic [31:0] exp, input int exp_stalls,
                           input logic st_too = 1'b0);
        int   stalls = 0;
        logic seen   = 1'b0;
        bus_if.Addr          = addr;
        bus_if.Wr_Data       = 32'h1234_5678;
        bus_if.Lw_Sw_OP      = op;
        bus_if.Store_Word_En = st_too;
        bus_if.Read_Ctrl     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (!bus_if.Mem_Stall) begin
                seen = 1'b1;
                check({tag, "_valid"}, {31'b0, bus_if.Rd_Valid}, 32'd1);
                check({tag, "_data"}, bus_if.Rd_Data, exp);
                break;
            end
            stalls++;
            @(posedge Clk); #1;
        end
        check({tag, "_done"}, {31'b0, seen}, 32'd1);
        check({tag, "_stalls"}, stalls, exp_stalls);
        @(posedge Clk); #1;
        idle_bus();
        @(negedge Clk);
        check({tag, "_valid_drop"}, {31'b0, bus_if.Rd_Valid}, 32'd0);
        @(posedge Clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_bus();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_rd_data",   bus_if.Rd_Data, 32'h0);
        check("rst_rd_valid",  {31'b0, bus_if.Rd_Valid}, 32'd0);
        check("rst_mem_stall", {31'b0, bus_if.Mem_Stall}, 32'd0);
        @(posedge Clk); #1;

        // Word store then load
        do_store("sw_10", 32'h10, 3'b010, 32'hDEAD_BEEF, 0);
        do_load ("lw_10", 32'h10, 3'b010, 32'hDEAD_BEEF, 1);

        // Byte lane 3 store, signed/unsigned loads, neighbours preserved
        do_store("sb_13",  32'h13, 3'b000, 32'hFFFF_FF80, 0);
        do_load ("lb_13",  32'h13, 3'b000, 32'hFFFF_FF80, 1);
        do_load ("lbu_13", 32'h13, 3'b100, 32'h0000_0080, 1);
        do_load ("lw_10b", 32'h10, 3'b010, 32'h80AD_BEEF, 1);

        // Misaligned halfword across words 1 and 2
        do_store("sh_07",  32'h07, 3'b001, 32'h0000_A55A, 1);
        do_load ("lhu_07", 32'h07, 3'b101, 32'h0000_A55A, 2);
        do_load ("lh_07",  32'h07, 3'b001, 32'hFFFF_A55A, 2);
        do_load ("lbu_07", 32'h07, 3'b100, 32'h0000_005A, 1);
        do_load ("lbu_08", 32'h08, 3'b100, 32'h0000_00A5, 1);

        // Wrap from word 1023 to word 0, plus address aliasing
        do_store("sw_ffe",  32'hFFE,  3'b010, 32'h1122_3344, 1);
        do_load ("lw_ffe",  32'hFFE,  3'b010, 32'h1122_3344, 2);
        do_load ("lhu_ffe", 32'hFFE,  3'b101, 32'h0000_3344, 1);
        do_load ("lhu_000", 32'h000,  3'b101, 32'h0000_1122, 1);
        do_load ("lw_alias", 32'h1010, 3'b010, 32'h80AD_BEEF, 1);

        // Back-to-back aligned stores, then a word load straddling them
        do_store("sw_20", 32'h20, 3'b010, 32'hCAFE_F00D, 0);
        do_store("sw_24", 32'h24, 3'b010, 32'h0102_0304, 0);
        do_load ("lw_22", 32'h22, 3'b010, 32'h0304_CAFE, 2);
        do_load ("lw_op7", 32'h20, 3'b111, 32'hCAFE_F00D, 1);

        // Both requests high: behaves as a load, no write
        do_load ("illegal", 32'h10, 3'b010, 32'h80AD_BEEF, 1, 1'b1);
        do_load ("lw_after_illegal", 32'h10, 3'b010, 32'h80AD_BEEF, 1);

        // No request
        bus_if.Addr    = 32'h10;
        bus_if.Wr_Data = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("noop_stall", {31'b0, bus_if.Mem_Stall}, 32'd0);
            check("noop_valid", {31'b0, bus_if.Rd_Valid}, 32'd0);
            @(posedge Clk); #1;
        end
        idle_bus();
        do_load ("lw_after_noop", 32'h10, 3'b010, 32'h80AD_BEEF, 1);

        // Reset while a split load sits in RD1
        bus_if.Addr      = 32'h21;
        bus_if.Lw_Sw_OP  = 3'b010;
        bus_if.Read_Ctrl = 1'b1;
        @(negedge Clk);
        check("rst_mid_idle_stall", {31'b0, bus_if.Mem_Stall}, 32'd1);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rst_mid_rd1_stall", {31'b0, bus_if.Mem_Stall}, 32'd1);
        Rst = 1'b1;
        idle_bus();
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_mid_stall", {31'b0, bus_if.Mem_Stall}, 32'd0);
        check("rst_mid_valid", {31'b0, bus_if.Rd_Valid}, 32'd0);
        check("rst_mid_data",  bus_if.Rd_Data, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            check("rst_mid_no_pulse", {31'b0, bus_if.Rd_Valid}, 32'd0);
        end
        @(posedge Clk); #1;
        do_load ("lw_after_rst", 32'h20, 3'b010, 32'hCAFE_F00D, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
